rx_symbol_scheduler: RTL
========================

Name: rx_symbol_scheduler

Overview:
Sequences the multi-standard OFDM receive datapath.
- Owns the reconfiguration handshake: issues config_update to the sync detectors and deasserts tready_global while the pipeline drains.
- After combined sync, steps through CP-skip and FFT-window phases symbol by symbol and marks the samples belonging to each useful symbol.
- Sits between mode_ctrl / sync combining and the demapper/FFT stage, and replaces the raw sync-level gating of sym_valid.

Parameters:
SYMS_PER_FRAME, 14, OFDM symbols per frame before re-searching sync.
SYNC_TIMEOUT, 65535, accepted samples in SEARCH without sync before a sync_lost pulse.
DRAIN_CYCLES, 16, clock cycles tready_global stays low after a config_update.
SYM_W, 4, width of sym_idx; must satisfy 2^SYM_W >= SYMS_PER_FRAME.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode_sel  in  2  requested standard
fft_len  in  13  FFT length from mode_ctrl
cp_len  in  9  CP length from mode_ctrl
din_valid  in  1  input sample strobe
sync_found  in  1  combined sync level (sync_found_combined)
config_update  out  1  one-cycle reconfiguration pulse to the sync detectors
tready_global  out  1  upstream flow control
sym_start  out  1  pulse on the first useful sample of a symbol
sym_data_valid  out  1  sample lies inside the FFT window
sample_idx  out  13  index of the sample within the FFT window
sym_idx  out  SYM_W  symbol index within the frame
frame_done  out  1  pulse on the last sample of the last symbol
sync_lost  out  1  pulse when the SEARCH timeout expires
cfg_err  out  1  level: latched fft_len is 0
state_out  out  3  current state, for debug

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0, state IDLE, tready_global 0.
- All outputs are registered.
- accept = din_valid && tready_global. Every sample counter advances only on accept.

States (encoding IDLE=0, RECONFIG=1, SEARCH=2, SKIP_CP=3, SYMBOL=4):
- IDLE:
  - Next cycle: go to RECONFIG, pulse config_update, capture mode_sel into mode_q.
- RECONFIG:
  - tready_global=0.
  - Drain counter counts DRAIN_CYCLES clock cycles (not samples).
  - At expiry: latch fft_len/cp_len into cfg_fft/cfg_cp, go to SEARCH, set tready_global=1 the following cycle.
- SEARCH:
  - If cfg_err: stay in SEARCH and ignore sync_found.
  - On accept with sync_found=1: go to SKIP_CP if cfg_cp!=0, else to SYMBOL; sym_idx=0.
  - Timeout counter counts accepts without sync. Reaching SYNC_TIMEOUT pulses sync_lost, clears the counter, and stays in SEARCH.
- SKIP_CP:
  - Counts cfg_cp accepts, then goes to SYMBOL.
  - The first SYMBOL sample is the accept after the last CP accept.
- SYMBOL:
  - Each accept sets sym_data_valid=1 one cycle later, with sample_idx = 0..cfg_fft-1.
  - sym_start=1 with sample_idx 0.
  - On sample cfg_fft-1:
    - If sym_idx == SYMS_PER_FRAME-1: pulse frame_done with that sample, go to SEARCH, reset sym_idx and the timeout counter.
    - Otherwise: sym_idx+1, go to SKIP_CP (or SYMBOL if cfg_cp==0).

Mode change and config rules:
- If mode_sel != mode_q in any state except IDLE: capture mode_q, pulse config_update, go to RECONFIG, restart the drain counter.
- Mode change has priority over all other transitions on that cycle. Any symbol in flight is abandoned without frame_done.
- fft_len/cp_len changes outside RECONFIG are ignored until the next reconfiguration.
- cfg_err = (cfg_fft == 0). It is updated only at the RECONFIG exit.

Other boundary rules:
- sync_found is ignored outside SEARCH.
- A loss of sync mid-symbol does not abort the symbol.
- din_valid while tready_global=0 is dropped (not counted).
- Back-to-back accepts sustain one sample per cycle with no bubbles at state boundaries.
- Latency: 1 cycle from accept to sym_data_valid / sample_idx / sym_start / frame_done.

Decomposition:
- Package rx_sched_pkg: state enum, state widths, FFT_W=13, CP_W=9.
- Natural sub-module: rx_len_counter, a loadable down-counter with an accept enable and a terminal-count flag. It is instantiated for the CP/FFT window count, the drain count and the timeout count.

Test Plan:
1. Reset release, fft_len=64, cp_len=16 -> config_update pulse in the cycle after IDLE; tready_global low for 16 cycles, then high.
2. sync_found on accept 5, continuous din_valid -> 16 samples skipped, then sym_data_valid for 64 cycles with sample_idx 0..63 and sym_start on idx 0; next symbol follows after 16 more CP samples.
3. SYMS_PER_FRAME=2, cp=16, fft=64 -> frame_done coincident with sym_idx=1, sample_idx=63; state returns to SEARCH(2).
4. mode_sel changed 0->1 at sample_idx 30 -> config_update pulse, sym_data_valid drops, tready_global low for 16 cycles, new fft_len/cp_len used; no frame_done.
5. SYNC_TIMEOUT=100, no sync -> sync_lost pulses after 100 accepts, again after 200; din_valid gaps do not advance the count.
6. cp_len=0, then fft_len=0 on a later reconfig -> symbols run back-to-back with no skip; after the fft_len=0 reconfig, cfg_err=1 and sync_found is ignored.

Source files
------------

// File: rtl/rx_sched_pkg.sv
// Shared types and widths for the OFDM receive symbol scheduler.
package rx_sched_pkg;

    localparam int FFT_W   = 13;
    localparam int CP_W    = 9;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RECONFIG = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_SKIP_CP  = 3'd3,
        ST_SYMBOL   = 3'd4
    } sched_state_t;

    // Window counter load value when a new symbol begins: the CP length if
    // there is a cyclic prefix to skip, otherwise straight into the FFT window.
    function automatic logic [FFT_W-1:0] window_load(input logic [FFT_W-1:0] fft,
                                                     input logic [CP_W-1:0]  cp);
        logic [FFT_W-1:0] cp_ext;
        cp_ext = {{(FFT_W-CP_W){1'b0}}, cp};
        return (cp != '0) ? (cp_ext - FFT_W'(1)) : (fft - FFT_W'(1));
    endfunction

endpackage

// File: rtl/rx_symbol_scheduler_if.sv
// Handshake/bus bundle between mode control, sync combining and the scheduler.
interface rx_symbol_scheduler_if #(parameter int SYM_W = 4) ();
    import rx_sched_pkg::*;

    logic [1:0]         mode_sel;
    logic [FFT_W-1:0]   fft_len;
    logic [CP_W-1:0]    cp_len;
    logic               din_valid;
    logic               sync_found;

    logic               config_update;
    logic               tready_global;
    logic               sym_start;
    logic               sym_data_valid;
    logic [FFT_W-1:0]   sample_idx;
    logic [SYM_W-1:0]   sym_idx;
    logic               frame_done;
    logic               sync_lost;
    logic               cfg_err;
    logic [STATE_W-1:0] state_out;

    modport slave (
        input  mode_sel, fft_len, cp_len, din_valid, sync_found,
        output config_update, tready_global, sym_start, sym_data_valid,
               sample_idx, sym_idx, frame_done, sync_lost, cfg_err, state_out
    );

    modport master (
        output mode_sel, fft_len, cp_len, din_valid, sync_found,
        input  config_update, tready_global, sym_start, sym_data_valid,
               sample_idx, sym_idx, frame_done, sync_lost, cfg_err, state_out
    );

endinterface

// File: rtl/rx_len_counter.sv
// Loadable down-counter with enable and terminal-count flag (count == 0).
module rx_len_counter #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Load wins over enable; the count parks at zero until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/rx_symbol_scheduler.sv
// OFDM receive symbol scheduler: reconfiguration drain, sync search with
// timeout, CP skipping and FFT-window marking, one sample per accept.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset; moves to RECONFIG on the next cycle
// RECONFIG | upstream stalled while the pipeline drains, then latch cfg
// SEARCH   | waiting for combined sync; counts accepts for the timeout
// SKIP_CP  | discarding cyclic-prefix samples of the current symbol
// SYMBOL   | marking samples inside the FFT window
module rx_symbol_scheduler
    import rx_sched_pkg::*;
#(
    parameter int SYMS_PER_FRAME = 14,
    parameter int SYNC_TIMEOUT   = 65535,
    parameter int DRAIN_CYCLES   = 16,
    parameter int SYM_W          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rx_symbol_scheduler_if.slave  bus
);

    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TMO_W = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(SYNC_TIMEOUT - 1);
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(SYMS_PER_FRAME - 1);

    sched_state_t     r_state;
    logic [1:0]       r_mode_q;
    logic [FFT_W-1:0] r_cfg_fft;
    logic [CP_W-1:0]  r_cfg_cp;
    logic             r_cfg_err;
    logic [SYM_W-1:0] r_sym_cnt;
    logic             r_tready;
    logic             r_config_update;
    logic             r_sym_start;
    logic             r_sym_data_valid;
    logic [FFT_W-1:0] r_sample_idx;
    logic [SYM_W-1:0] r_sym_idx;
    logic             r_frame_done;
    logic             r_sync_lost;

    logic             w_accept;
    logic             w_mode_chg;
    logic             w_sync_go;
    logic             w_frame_end;
    logic             w_tmo_search;
    logic             w_drain_done;

    logic             w_drn_load;
    logic             w_drn_en;
    logic             w_drn_tc;
    logic [DRN_W-1:0] w_unused_drn_count;

    logic             w_win_load;
    logic [FFT_W-1:0] w_win_val;
    logic             w_win_en;
    logic             w_win_tc;
    logic [FFT_W-1:0] w_win_count;

    logic             w_tmo_load;
    logic             w_tmo_en;
    logic             w_tmo_tc;
    logic [TMO_W-1:0] w_unused_tmo_count;

    // Counter controls; these track the transitions taken by the FSM below.
    always_comb begin
        w_accept     = bus.din_valid && r_tready;
        w_mode_chg   = (r_state != ST_IDLE) && (bus.mode_sel != r_mode_q);
        w_sync_go    = (r_state == ST_SEARCH) && w_accept && bus.sync_found && !r_cfg_err;
        w_frame_end  = (r_state == ST_SYMBOL) && w_accept && w_win_tc && (r_sym_cnt == LAST_SYM);
        w_tmo_search = (r_state == ST_SEARCH) && w_accept && !w_sync_go;
        w_drain_done = (r_state == ST_RECONFIG) && w_drn_tc && !w_mode_chg;

        w_drn_load   = (r_state == ST_IDLE) || w_mode_chg;
        w_drn_en     = (r_state == ST_RECONFIG);

        w_win_load   = 1'b0;
        w_win_val    = '0;
        if (!w_mode_chg) begin
            if (w_sync_go) begin
                w_win_load = 1'b1;
                w_win_val  = window_load(r_cfg_fft, r_cfg_cp);
            end else if ((r_state == ST_SKIP_CP) && w_accept && w_win_tc) begin
                w_win_load = 1'b1;
                w_win_val  = r_cfg_fft - FFT_W'(1);
            end else if ((r_state == ST_SYMBOL) && w_accept && w_win_tc && !w_frame_end) begin
                w_win_load = 1'b1;
                w_win_val  = window_load(r_cfg_fft, r_cfg_cp);
            end
        end
        w_win_en     = w_accept && ((r_state == ST_SKIP_CP) || (r_state == ST_SYMBOL));

        w_tmo_load   = w_drain_done || w_frame_end || (w_tmo_search && w_tmo_tc);
        w_tmo_en     = w_tmo_search;
    end

    rx_len_counter #(.W(DRN_W)) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_drn_load),
        .i_load_val (DRN_LOAD),
        .i_en       (w_drn_en),
        .o_count    (w_unused_drn_count),
        .o_tc       (w_drn_tc)
    );

    rx_len_counter #(.W(FFT_W)) u_window_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_win_load),
        .i_load_val (w_win_val),
        .i_en       (w_win_en),
        .o_count    (w_win_count),
        .o_tc       (w_win_tc)
    );

    rx_len_counter #(.W(TMO_W)) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmo_load),
        .i_load_val (TMO_LOAD),
        .i_en       (w_tmo_en),
        .o_count    (w_unused_tmo_count),
        .o_tc       (w_tmo_tc)
    );

    // Scheduler FSM with registered outputs; a mode change overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_mode_q         <= '0;
            r_cfg_fft        <= '0;
            r_cfg_cp         <= '0;
            r_cfg_err        <= 1'b0;
            r_sym_cnt        <= '0;
            r_tready         <= 1'b0;
            r_config_update  <= 1'b0;
            r_sym_start      <= 1'b0;
            r_sym_data_valid <= 1'b0;
            r_sample_idx     <= '0;
            r_sym_idx        <= '0;
            r_frame_done     <= 1'b0;
            r_sync_lost      <= 1'b0;
        end else begin
            r_config_update  <= 1'b0;
            r_sym_start      <= 1'b0;
            r_sym_data_valid <= 1'b0;
            r_frame_done     <= 1'b0;
            r_sync_lost      <= 1'b0;

            if (w_mode_chg) begin
                r_mode_q        <= bus.mode_sel;
                r_config_update <= 1'b1;
                r_tready        <= 1'b0;
                r_state         <= ST_RECONFIG;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_mode_q        <= bus.mode_sel;
                        r_config_update <= 1'b1;
                        r_tready        <= 1'b0;
                        r_state         <= ST_RECONFIG;
                    end
                    ST_RECONFIG: begin
                        if (w_drn_tc) begin
                            r_cfg_fft <= bus.fft_len;
                            r_cfg_cp  <= bus.cp_len;
                            r_cfg_err <= (bus.fft_len == '0);
                            r_sym_cnt <= '0;
                            r_tready  <= 1'b1;
                            r_state   <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (w_sync_go) begin
                            r_sym_cnt <= '0;
                            r_sym_idx <= '0;
                            r_state   <= (r_cfg_cp != '0) ? ST_SKIP_CP : ST_SYMBOL;
                        end else if (w_tmo_search && w_tmo_tc) begin
                            r_sync_lost <= 1'b1;
                        end
                    end
                    ST_SKIP_CP: begin
                        if (w_accept && w_win_tc) begin
                            r_state <= ST_SYMBOL;
                        end
                    end
                    ST_SYMBOL: begin
                        if (w_accept) begin
                            r_sym_data_valid <= 1'b1;
                            r_sample_idx     <= r_cfg_fft - FFT_W'(1) - w_win_count;
                            r_sym_start      <= (w_win_count == (r_cfg_fft - FFT_W'(1)));
                            r_sym_idx        <= r_sym_cnt;
                            if (w_win_tc) begin
                                if (r_sym_cnt == LAST_SYM) begin
                                    r_frame_done <= 1'b1;
                                    r_sym_cnt    <= '0;
                                    r_state      <= ST_SEARCH;
                                end else begin
                                    r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                                    r_state   <= (r_cfg_cp != '0) ? ST_SKIP_CP : ST_SYMBOL;
                                end
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.config_update  = r_config_update;
    assign bus.tready_global  = r_tready;
    assign bus.sym_start      = r_sym_start;
    assign bus.sym_data_valid = r_sym_data_valid;
    assign bus.sample_idx     = r_sample_idx;
    assign bus.sym_idx        = r_sym_idx;
    assign bus.frame_done     = r_frame_done;
    assign bus.sync_lost      = r_sync_lost;
    assign bus.cfg_err        = r_cfg_err;
    assign bus.state_out      = r_state;

endmodule
